// File: rtl/onchip_mem_dp_pipelined.sv
// onchip_mem_dp_pipelined: true-dual-port RAM with two Avalon-MM slaves, zero-fill after reset, pipelined reads
//   clk, reset (async, active-high), clken (low freezes all state)
//   sN_address/byteenable/chipselect/read/write/writedata -> request inputs for port N (N = 1, 2)
//   sN_readdata/readdatavalid/waitrequest                  -> response outputs for port N
//   init_done                                               -> high once the memory is usable
module onchip_mem_dp_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 10000,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic run, in1, in2, acc1, acc2, we1, we2, re1, re2;
  logic [IW-1:0] i1, i2;
  logic [DATA_WIDTH-1:0] fwd1, fwd2, rd1, rd2;
  logic [READ_LATENCY-1:0] v1, v2;
  logic [DATA_WIDTH-1:0] d1 [READ_LATENCY];
  logic [DATA_WIDTH-1:0] d2 [READ_LATENCY];
  always_comb begin
    state_nx = state;
    cnt_nx = (state == INIT) ? cnt + 1'b1 : cnt;
    if (state == INIT && (!CLEAR_ON_RESET || cnt == LAST))
      state_nx = RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
    end else if (clken) begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  assign run = state == RUN;
  assign init_done = run;
  assign s1_waitrequest = ~run | ~clken;
  assign s2_waitrequest = ~run | ~clken;
  assign in1 = {1'b0, s1_address} < DEPTH_W;
  assign in2 = {1'b0, s2_address} < DEPTH_W;
  assign i1 = s1_address[IW-1:0];
  assign i2 = s2_address[IW-1:0];
  assign acc1 = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
  assign acc2 = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
  assign we1 = acc1 & s1_write & in1;
  assign we2 = acc2 & s2_write & in2;
  // a read paired with a write on the same port is dropped
  assign re1 = acc1 & s1_read & ~s1_write;
  assign re2 = acc2 & s2_read & ~s2_write;
  // s1 is applied last so it owns any byte both ports enable
  always_ff @(posedge clk) begin
    if (clken && state == INIT && CLEAR_ON_RESET)
      mem[cnt[IW-1:0]] <= '0;
    for (int b = 0; b < NB; b++) begin
      if (we2 && s2_byteenable[b]) mem[i2][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      if (we1 && s1_byteenable[b]) mem[i1][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end
  // write-first: a read sees the other port's same-cycle write merged over the stored word
  always_comb begin
    fwd1 = mem[i1];
    fwd2 = mem[i2];
    for (int b = 0; b < NB; b++) begin
      if (we2 && s2_address == s1_address && s2_byteenable[b]) fwd1[b*8 +: 8] = s2_writedata[b*8 +: 8];
      if (we1 && s1_address == s2_address && s1_byteenable[b]) fwd2[b*8 +: 8] = s1_writedata[b*8 +: 8];
    end
    rd1 = in1 ? fwd1 : '0;
    rd2 = in2 ? fwd2 : '0;
  end
  // each stage only loads data when its source is valid, so readdata holds between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= '0;
      v2 <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        d1[k] <= '0;
        d2[k] <= '0;
      end
    end else if (clken) begin
      v1[0] <= re1;
      v2[0] <= re2;
      if (re1) d1[0] <= rd1;
      if (re2) d2[0] <= rd2;
      for (int k = 1; k < READ_LATENCY; k++) begin
        v1[k] <= v1[k-1];
        v2[k] <= v2[k-1];
        if (v1[k-1]) d1[k] <= d1[k-1];
        if (v2[k-1]) d2[k] <= d2[k-1];
      end
    end
  end
  assign s1_readdatavalid = v1[READ_LATENCY-1];
  assign s2_readdatavalid = v2[READ_LATENCY-1];
  assign s1_readdata = d1[READ_LATENCY-1];
  assign s2_readdata = d2[READ_LATENCY-1];
endmodule

// File: tb/tb_onchip_mem_dp_pipelined.sv
// tb_onchip_mem_dp_pipelined: table vectors, corner sequences and random traffic against a transaction-level model
module tb_onchip_mem_dp_pipelined;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 5;
  localparam int LAT = 2;
  logic clk, reset, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest, init_done;
  onchip_mem_dp_pipelined #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .init_done(init_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {int due; logic [31:0] d;} pend_t;
  typedef struct {int port; bit wr; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] exp;} vec_t;
  logic [31:0] mm [DEPTH];
  pend_t q1[$], q2[$];
  bit run, ev1, ev2;
  logic [31:0] ed1, ed2;
  int init_left, edges, checks, errors;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction
  task automatic model_reset();
    run = 0;
    init_left = DEPTH;
    edges = 0;
    q1.delete();
    q2.delete();
    ev1 = 0;
    ev2 = 0;
    ed1 = 0;
    ed2 = 0;
    foreach (mm[i]) mm[i] = 0;
  endtask
  // one enabled edge: all writes land first, then reads see the resulting words
  task automatic model_edge();
    bit w1, w2, r1, r2;
    if (reset || !clken) return;
    edges++;
    if (!run) begin
      init_left--;
      run = (init_left == 0);
    end else begin
      w1 = s1_chipselect && s1_write && s1_address < DEPTH;
      w2 = s2_chipselect && s2_write && s2_address < DEPTH;
      r1 = s1_chipselect && s1_read && !s1_write;
      r2 = s2_chipselect && s2_read && !s2_write;
      if (w2) mm[s2_address[3:0]] = merge(mm[s2_address[3:0]], s2_writedata, s2_byteenable);
      if (w1) mm[s1_address[3:0]] = merge(mm[s1_address[3:0]], s1_writedata, s1_byteenable);
      if (r1) q1.push_back('{edges + LAT - 1, (s1_address < DEPTH) ? mm[s1_address[3:0]] : 32'h0});
      if (r2) q2.push_back('{edges + LAT - 1, (s2_address < DEPTH) ? mm[s2_address[3:0]] : 32'h0});
    end
    ev1 = q1.size() > 0 && q1[0].due == edges;
    if (ev1) ed1 = q1.pop_front().d;
    ev2 = q2.size() > 0 && q2[0].due == edges;
    if (ev2) ed2 = q2.pop_front().d;
  endtask
  task automatic check_outputs();
    chk1("wait1", s1_waitrequest, !run || !clken);
    chk1("wait2", s2_waitrequest, !run || !clken);
    chk1("init_done", init_done, run);
    chk1("rdv1", s1_readdatavalid, ev1);
    chk1("rdv2", s2_readdatavalid, ev2);
    chk("rdata1", s1_readdata, ed1);
    chk("rdata2", s2_readdata, ed2);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask
  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask
  task automatic drive(input int p, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask
  task automatic rd_chk(input string nm, input int p, input logic [AW-1:0] a, input logic [31:0] exp);
    bit ok;
    ok = 0;
    idle();
    drive(p, 1, 0, a, 4'h0, 32'h0);
    tick();
    idle();
    for (int k = 0; k < 6 && !ok; k++) begin
      if (p == 1 ? s1_readdatavalid : s2_readdatavalid) begin
        ok = 1;
        chk(nm, p == 1 ? s1_readdata : s2_readdata, exp);
      end else tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no readdatavalid within 6 cycles, expected data %h", nm, exp);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[17];
    logic [31:0] b2b_exp[4];
    logic [AW-1:0] b2b_addr[4];
    logic [31:0] got[$];
    int n, first, last, strobes;
    tbl[0]  = '{1, 1, 5,  4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 0, 5,  4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 1, 7,  4'hF, 32'h11223344, 32'h0};
    tbl[3]  = '{1, 1, 7,  4'h5, 32'hAABBCCDD, 32'h0};
    tbl[4]  = '{1, 0, 7,  4'h0, 32'h0,        32'h11BB33DD};
    tbl[5]  = '{2, 0, 2,  4'h0, 32'h0,        32'h0};
    tbl[6]  = '{1, 1, 20, 4'hF, 32'h12345678, 32'h0};
    tbl[7]  = '{1, 0, 20, 4'h0, 32'h0,        32'h0};
    tbl[8]  = '{2, 0, 4,  4'h0, 32'h0,        32'h0};
    tbl[9]  = '{2, 0, 5,  4'h0, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{2, 1, 9,  4'hC, 32'hCAFEF00D, 32'h0};
    tbl[11] = '{1, 0, 9,  4'h0, 32'h0,        32'hCAFE0000};
    tbl[12] = '{2, 1, 16, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[13] = '{1, 0, 0,  4'h0, 32'h0,        32'h0};
    tbl[14] = '{2, 0, 15, 4'h0, 32'h0,        32'h0};
    tbl[15] = '{1, 1, 9,  4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[16] = '{1, 0, 9,  4'h0, 32'h0,        32'hCAFE0000};
    checks = 0;
    errors = 0;
    s1_address = 0; s1_byteenable = 0; s1_writedata = 0;
    s2_address = 0; s2_byteenable = 0; s2_writedata = 0;
    idle();
    clken = 1;
    reset = 1;
    model_reset();
    tick();
    tick();
    reset = 0;
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk("init_len", n, DEPTH);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) begin
        idle();
        drive(tbl[i].port, 0, 1, tbl[i].addr, tbl[i].be, tbl[i].wdata);
        tick();
        idle();
      end else rd_chk($sformatf("vec%0d", i), tbl[i].port, tbl[i].addr, tbl[i].exp);
    end
    idle();
    drive(1, 0, 1, 3, 4'b0001, 32'h000000FF);
    drive(2, 0, 1, 3, 4'b0011, 32'h0000AA00);
    tick();
    rd_chk("coll_ww", 1, 3, 32'h0000AAFF);
    idle();
    drive(1, 0, 1, 3, 4'b1000, 32'h12000000);
    drive(2, 1, 0, 3, 4'h0, 32'h0);
    tick();
    idle();
    tick();
    chk1("coll_fwd_v", s2_readdatavalid, 1'b1);
    chk("coll_fwd_d", s2_readdata, 32'h1200AAFF);
    b2b_addr[0] = 5; b2b_addr[1] = 7; b2b_addr[2] = 9; b2b_addr[3] = 3;
    b2b_exp[0] = 32'hDEADBEEF; b2b_exp[1] = 32'h11BB33DD; b2b_exp[2] = 32'hCAFE0000; b2b_exp[3] = 32'h1200AAFF;
    first = -1;
    last = -1;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 4) drive(1, 1, 0, b2b_addr[i], 4'h0, 32'h0);
      tick();
      if (s1_readdatavalid) begin
        got.push_back(s1_readdata);
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_count", got.size(), 4);
    chk("b2b_span", last - first, 3);
    chk("b2b_first", first, LAT - 1);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("b2b_d%0d", i), got[i], b2b_exp[i]);
    idle();
    drive(1, 1, 1, 10, 4'hF, 32'h55AA55AA);
    tick();
    idle();
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s1_readdatavalid) strobes++;
    end
    chk("rw_drop", strobes, 0);
    rd_chk("rw_write", 1, 10, 32'h55AA55AA);
    idle();
    drive(2, 1, 0, 5, 4'h0, 32'h0);
    tick();
    idle();
    clken = 0;
    drive(1, 0, 1, 5, 4'hF, 32'h0BADBAD0);
    tick();
    tick();
    chk1("ck_hold_v", s2_readdatavalid, 1'b0);
    idle();
    clken = 1;
    tick();
    chk1("ck_resume_v", s2_readdatavalid, 1'b1);
    chk("ck_resume_d", s2_readdata, 32'hDEADBEEF);
    rd_chk("ck_no_write", 1, 5, 32'hDEADBEEF);
    idle();
    drive(1, 1, 0, 5, 4'h0, 32'h0);
    drive(2, 1, 0, 7, 4'h0, 32'h0);
    tick();
    idle();
    reset = 1;
    model_reset();
    tick();
    chk1("rst_v1", s1_readdatavalid, 1'b0);
    chk1("rst_v2", s2_readdatavalid, 1'b0);
    tick();
    reset = 0;
    n = 0;
    while (!init_done && n < 100) begin
      clken = (n >= 5 && n < 8) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    clken = 1;
    chk("init_len_clken", n, DEPTH + 3);
    rd_chk("rst_zero", 1, 5, 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1;
        model_reset();
      end else reset = 0;
      clken = $urandom_range(7) != 0;
      s1_chipselect = $urandom_range(3) != 0;
      s1_read = $urandom_range(1) == 1;
      s1_write = $urandom_range(2) == 0;
      s1_address = AW'($urandom_range(19));
      s1_byteenable = 4'($urandom_range(15));
      s1_writedata = $urandom;
      s2_chipselect = $urandom_range(3) != 0;
      s2_read = $urandom_range(1) == 1;
      s2_write = $urandom_range(2) == 0;
      s2_address = AW'($urandom_range(19));
      s2_byteenable = 4'($urandom_range(15));
      s2_writedata = $urandom;
      tick();
    end
    reset = 0;
    clken = 1;
    idle();
    for (int i = 0; i < 4; i++) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
